// File: rtl/tm_lif_scheduler.sv
// tm_lif_scheduler: timestep sweep sequencer for the shared 3-stage LIF core.
// Optional spike counter output enabled by TM_LIF_SPIKE_COUNT_EN.
module tm_lif_scheduler #(
  parameter int N_NEURONS  = 256,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              tick,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] syn_addr,
  input  logic [9:0]        syn_data,
  output logic [9:0]        core_vmem,
  output logic [9:0]        core_syn,
  input  logic [9:0]        core_vmem_o,
  input  logic              core_spike,
  output logic              spk_valid,
  output logic [ADDR_W-1:0] spk_idx,
  input  logic              spk_ready
`ifdef TM_LIF_SPIKE_COUNT_EN
  ,
  output logic [ADDR_W:0]   spk_count
`endif
);

  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam int FC_W  = FA_W + 1;
  localparam int SUM_W = FC_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_done;

  logic [3:0]        r_pv;
  logic [ADDR_W-1:0] r_pidx [4];

  logic [9:0]        r_mem [N_NEURONS];

  logic [ADDR_W-1:0] r_fifo [FIFO_DEPTH];
  logic [FA_W-1:0]   r_fwr;
  logic [FA_W-1:0]   r_frd;
  logic [FC_W-1:0]   r_fcnt;

  logic [2:0]        w_inflight;
  logic [SUM_W-1:0]  w_occ;
  logic              w_credit;
  logic              w_issue_st;
  logic              w_issuing;
  logic              w_last;
  logic              w_drained;
  logic              w_wb;
  logic [ADDR_W-1:0] w_wb_idx;
  logic              w_full;
  logic              w_pop;
  logic              w_push;

  // Credit: every slot in flight may still push one event.
  assign w_inflight = {2'b00, r_pv[0]} + {2'b00, r_pv[1]}
                    + {2'b00, r_pv[2]} + {2'b00, r_pv[3]};
  assign w_occ      = SUM_W'(r_fcnt) + SUM_W'(w_inflight);
  assign w_credit   = w_occ < SUM_W'(FIFO_DEPTH);

  assign w_issue_st = (r_state == S_FETCH) || (r_state == S_RUN);
  assign w_issuing  = w_issue_st && w_credit;
  assign w_last     = r_rd_ptr == ADDR_W'(N_NEURONS - 1);
  assign w_drained  = ~|r_pv[2:0];

  assign w_wb       = r_pv[3];
  assign w_wb_idx   = r_pidx[3];

  assign w_full     = r_fcnt == FC_W'(FIFO_DEPTH);
  assign w_pop      = (r_fcnt != '0) && spk_ready;
  assign w_push     = w_wb && core_spike && (!w_full || w_pop);

  assign busy       = r_state != S_IDLE;
  assign done       = r_done;
  assign syn_addr   = r_rd_ptr;

  assign core_syn   = r_pv[0] ? syn_data : 10'd0;
  assign core_vmem  = r_pv[0] ? r_mem[r_pidx[0]] : 10'd0;

  assign spk_valid  = r_fcnt != '0;
  assign spk_idx    = r_fifo[r_frd];

  // Sweep control: issue indices, then wait for the pipe to empty.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rd_ptr <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tick) begin
            r_state  <= S_FETCH;
            r_rd_ptr <= '0;
          end
        end
        S_FETCH, S_RUN: begin
          if (w_issuing) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_state  <= w_last ? S_DRAIN : S_RUN;
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Slot tracker: entry 0 is the core issue cycle, entry 3 writeback.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_pv <= '0;
      for (int i = 0; i < 4; i++) r_pidx[i] <= '0;
    end else begin
      r_pv      <= {r_pv[2:0], w_issuing};
      r_pidx[0] <= r_rd_ptr;
      for (int i = 1; i < 4; i++) r_pidx[i] <= r_pidx[i-1];
    end
  end

  // Membrane state array, written only by valid writeback slots.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) r_mem[i] <= '0;
    end else if (w_wb) begin
      r_mem[w_wb_idx] <= core_vmem_o;
    end
  end

  // Spike event FIFO storage and pointers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_fwr <= '0;
      r_frd <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_fwr] <= w_wb_idx;
        r_fwr         <= r_fwr + FA_W'(1);
      end
      if (w_pop) r_frd <= r_frd + FA_W'(1);
    end
  end

  // FIFO occupancy; push+pop together leaves it unchanged.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_fcnt <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + FC_W'(1);
        2'b01:   r_fcnt <= r_fcnt - FC_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

`ifdef TM_LIF_SPIKE_COUNT_EN
  logic [ADDR_W:0] r_spk_count;

  assign spk_count = r_spk_count;

  // Per-sweep spike tally, cleared when a sweep is accepted.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_spk_count <= '0;
    end else if ((r_state == S_IDLE) && tick) begin
      r_spk_count <= '0;
    end else if (w_wb && core_spike) begin
      r_spk_count <= r_spk_count + (ADDR_W+1)'(1);
    end
  end
`endif

endmodule
